// File: rtl/mem_access.sv
// mem_access: load/store unit sitting between execute and writeback.
// Issues one data-memory access per load/store, handles byte/half/word
// lanes, sign/zero extension, misalignment and an optional bus timeout.
// Optional feature macro: MEM_ACCESS_TIMEOUT_EN (adds 32-cycle access timeout
// and a bus_err_o pulse; without it bus_err_o is tied low).
// Datapath lanes assume XLEN = 32.

package mem_access_pkg;
    typedef enum logic [2:0] {
        ZERO   = 3'd0,
        ALU    = 3'd1,
        LOAD   = 3'd2,
        STORE  = 3'd3,
        BRANCH = 3'd4,
        JUMP   = 3'd5,
        SYSTEM = 3'd6
    } operation_e;
endpackage

// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no access outstanding; aligned memory op raises request directly
// REQ   | request raised, waiting for grant (request fields held stable)
// WAIT  | granted, waiting for completion on dmem_rvalid_i
module mem_access
    import mem_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rstn_i,

    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instruction_i,
    input  logic [XLEN-1:0] alu_data_i,
    input  logic [XLEN-1:0] memory_write_addr_i,
    input  logic [XLEN-1:0] memory_write_data_i,
    input  logic [9:0]      memory_read_addr_i,
    input  logic            memory_read_enable_i,
    input  logic            memory_write_enable_i,
    input  logic            rd_write_enable_i,
    input  logic [4:0]      rf_addr_i,
    input  operation_e      operation_i,

    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    output logic [3:0]      dmem_be_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,

    output logic [XLEN-1:0] rd_data_o,
    output logic [4:0]      rf_addr_o,
    output logic            rd_write_enable_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instruction_o,
    output operation_e      operation_o,

    output logic            stall_o,
    output logic            misaligned_o,
    output logic            bus_err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   rd_data_q, rd_data_d;
    logic [4:0]        rf_addr_q, rf_addr_d;
    logic              rd_we_q, rd_we_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    operation_e        op_q, op_d;
    logic              mis_q, mis_d;

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic [5:0]        tmo_cnt_q, tmo_cnt_d;
    logic              bus_err_q, bus_err_d;
    logic              tmo_hit;
`endif

    logic              is_mem;
    logic              is_store;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   acc_addr;
    logic [1:0]        lsb;
    logic              sz_byte;
    logic              sz_half;
    logic              sz_word;
    logic              misaligned;
    logic              issue;
    logic              done;
    logic              stall;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [XLEN-1:0]   load_data;
    logic [3:0]        be;
    logic [XLEN-1:0]   wdata;

    // Decode the access: kind, address, width and alignment
    always_comb begin
        is_store   = memory_write_enable_i;
        is_mem     = memory_write_enable_i | memory_read_enable_i;
        funct3     = instruction_i[14:12];
        acc_addr   = is_store ? memory_write_addr_i
                              : {{(XLEN-10){1'b0}}, memory_read_addr_i};
        lsb        = acc_addr[1:0];
        sz_byte    = (funct3[1:0] == 2'b00);
        sz_half    = (funct3[1:0] == 2'b01);
        sz_word    = !sz_byte && !sz_half;
        misaligned = (sz_half && lsb[0]) || (sz_word && (lsb != 2'b00));
    end

    // Byte enables and lane-replicated store data
    always_comb begin
        be    = 4'b1111;
        wdata = memory_write_data_i;
        if (sz_byte) begin
            be    = 4'b0001 << lsb;
            wdata = {(XLEN/8){memory_write_data_i[7:0]}};
        end else if (sz_half) begin
            be    = 4'b0011 << lsb;
            wdata = {(XLEN/16){memory_write_data_i[15:0]}};
        end
    end

    // Select the addressed lane of the read data and extend it
    always_comb begin
        lane_b    = dmem_rdata_i[{lsb, 3'b000} +: 8];
        lane_h    = dmem_rdata_i[{lsb[1], 4'b0000} +: 16];
        load_data = dmem_rdata_i;
        if (sz_byte) begin
            load_data = {{(XLEN-8){lane_b[7] & ~funct3[2]}}, lane_b};
        end else if (sz_half) begin
            load_data = {{(XLEN-16){lane_h[15] & ~funct3[2]}}, lane_h};
        end
    end

    assign issue = (state_q == S_IDLE) && is_mem && !misaligned;
    assign done  = (state_q == S_WAIT) && dmem_rvalid_i;

`ifdef MEM_ACCESS_TIMEOUT_EN
    assign tmo_hit = (state_q != S_IDLE) && (tmo_cnt_q == 6'd31) && !done;
`endif

    // Upstream hold: pending request, or waiting without completion this cycle
    always_comb begin
        stall = issue || (state_q == S_REQ) || ((state_q == S_WAIT) && !dmem_rvalid_i);
`ifdef MEM_ACCESS_TIMEOUT_EN
        if (tmo_hit) begin
            stall = 1'b0;
        end
`endif
    end

    // Request fields come straight from the held upstream inputs, so they
    // stay stable from the first request cycle through the grant cycle.
    assign dmem_req_o   = rstn_i && (issue || (state_q == S_REQ));
    assign dmem_we_o    = is_store;
    assign dmem_addr_o  = {acc_addr[XLEN-1:2], 2'b00};
    assign dmem_be_o    = be;
    assign dmem_wdata_o = wdata;
    assign stall_o      = rstn_i && stall;

    // Next-state and writeback register update; stalled cycles capture a bubble
    always_comb begin
        state_d   = state_q;
        rd_data_d = rd_data_q;
        rf_addr_d = rf_addr_q;
        rd_we_d   = 1'b0;
        pc_d      = pc_q;
        instr_d   = instr_q;
        op_d      = op_q;
        mis_d     = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        bus_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (is_mem && !misaligned) begin
                    state_d = dmem_gnt_i ? S_WAIT : S_REQ;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    tmo_cnt_d = 6'd0;
`endif
                end else begin
                    rd_data_d = alu_data_i;
                    rf_addr_d = rf_addr_i;
                    rd_we_d   = rd_write_enable_i && !is_mem;
                    pc_d      = pc_i;
                    instr_d   = instruction_i;
                    op_d      = operation_i;
                    mis_d     = is_mem;
                end
            end
            S_REQ: begin
`ifdef MEM_ACCESS_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 6'd1;
`endif
                if (dmem_gnt_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
`ifdef MEM_ACCESS_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 6'd1;
`endif
                if (dmem_rvalid_i) begin
                    state_d   = S_IDLE;
                    rd_data_d = is_store ? alu_data_i : load_data;
                    rf_addr_d = rf_addr_i;
                    rd_we_d   = rd_write_enable_i && !is_store;
                    pc_d      = pc_i;
                    instr_d   = instruction_i;
                    op_d      = operation_i;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef MEM_ACCESS_TIMEOUT_EN
        if (tmo_hit) begin
            state_d   = S_IDLE;
            bus_err_d = 1'b1;
            rd_we_d   = 1'b0;
        end
`endif
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q   <= S_IDLE;
            rd_data_q <= '0;
            rf_addr_q <= '0;
            rd_we_q   <= 1'b0;
            pc_q      <= '0;
            instr_q   <= '0;
            op_q      <= ZERO;
            mis_q     <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            tmo_cnt_q <= '0;
            bus_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rd_data_q <= rd_data_d;
            rf_addr_q <= rf_addr_d;
            rd_we_q   <= rd_we_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            op_q      <= op_d;
            mis_q     <= mis_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            bus_err_q <= bus_err_d;
`endif
        end
    end

    assign rd_data_o         = rd_data_q;
    assign rf_addr_o         = rf_addr_q;
    assign rd_write_enable_o = rd_we_q;
    assign pc_o              = pc_q;
    assign instruction_o     = instr_q;
    assign operation_o       = op_q;
    assign misaligned_o      = mis_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
    assign bus_err_o         = bus_err_q;
`else
    assign bus_err_o         = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Directed testbench for mem_access: vector table plus hand-written
// sequences for grant delay, reset during an access and timeout.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [31:0] pc_i, instruction_i, alu_data_i, memory_write_addr_i, memory_write_data_i;
    logic [9:0]  memory_read_addr_i;
    logic        memory_read_enable_i, memory_write_enable_i, rd_write_enable_i;
    logic [4:0]  rf_addr_i;
    operation_e  operation_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic [31:0] rd_data_o;
    logic [4:0]  rf_addr_o;
    logic        rd_write_enable_o;
    logic [31:0] pc_o, instruction_o;
    operation_e  operation_o;
    logic        stall_o, misaligned_o, bus_err_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    mem_access #(.XLEN(32)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .pc_i(pc_i), .instruction_i(instruction_i), .alu_data_i(alu_data_i),
        .memory_write_addr_i(memory_write_addr_i), .memory_write_data_i(memory_write_data_i),
        .memory_read_addr_i(memory_read_addr_i),
        .memory_read_enable_i(memory_read_enable_i), .memory_write_enable_i(memory_write_enable_i),
        .rd_write_enable_i(rd_write_enable_i), .rf_addr_i(rf_addr_i), .operation_i(operation_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_gnt_i(dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .rd_data_o(rd_data_o), .rf_addr_o(rf_addr_o), .rd_write_enable_o(rd_write_enable_o),
        .pc_o(pc_o), .instruction_o(instruction_o), .operation_o(operation_o),
        .stall_o(stall_o), .misaligned_o(misaligned_o), .bus_err_o(bus_err_o)
    );

    typedef struct {
        logic       rd_en, wr_en, rwe;
        logic [2:0] f3;
        logic [9:0] raddr;
        logic [31:0] waddr, wdata, alu, rdata;
        int          dly;
        operation_e  op;
        logic        exp_req, exp_dwe;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr, exp_wdata, exp_rd;
        logic        chk_rd, exp_we, exp_mis;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_idle();
        pc_i = '0; instruction_i = '0; alu_data_i = '0;
        memory_write_addr_i = '0; memory_write_data_i = '0; memory_read_addr_i = '0;
        memory_read_enable_i = 1'b0; memory_write_enable_i = 1'b0; rd_write_enable_i = 1'b0;
        rf_addr_i = '0; operation_i = ZERO;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    endtask

    function automatic vec_t mk(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                                input logic [9:0] raddr, input logic [31:0] waddr,
                                input logic [31:0] wdata, input logic [31:0] alu,
                                input logic [31:0] rdata, input int dly, input logic exp_req,
                                input logic [3:0] exp_be, input logic [31:0] exp_addr,
                                input logic [31:0] exp_wdata, input logic [31:0] exp_rd,
                                input logic chk_rd, input logic exp_we, input logic exp_mis);
        vec_t v;
        v.rd_en = rd_en; v.wr_en = wr_en; v.rwe = 1'b1; v.f3 = f3;
        v.raddr = raddr; v.waddr = waddr; v.wdata = wdata; v.alu = alu; v.rdata = rdata;
        v.dly = dly;
        v.op = wr_en ? STORE : (rd_en ? LOAD : ALU);
        v.exp_req = exp_req; v.exp_dwe = wr_en; v.exp_be = exp_be; v.exp_addr = exp_addr;
        v.exp_wdata = exp_wdata; v.exp_rd = exp_rd; v.chk_rd = chk_rd;
        v.exp_we = exp_we; v.exp_mis = exp_mis;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] pc_e;
        pc_e = 32'h1000 + 32'(idx) * 4;
        pc_i = pc_e;
        instruction_i = {17'd0, v.f3, 12'h003};
        alu_data_i = v.alu;
        memory_read_addr_i = v.raddr;
        memory_write_addr_i = v.waddr;
        memory_write_data_i = v.wdata;
        memory_read_enable_i = v.rd_en;
        memory_write_enable_i = v.wr_en;
        rd_write_enable_i = v.rwe;
        rf_addr_i = 5'(idx + 1);
        operation_i = v.op;
        dmem_gnt_i = 1'b1;
        dmem_rvalid_i = 1'b0;
        @(negedge clk_i);
        chk($sformatf("v%0d req", idx), 32'(dmem_req_o), 32'(v.exp_req));
        chk($sformatf("v%0d stall0", idx), 32'(stall_o), 32'(v.exp_req));
        if (v.exp_req) begin
            chk($sformatf("v%0d addr", idx), dmem_addr_o, v.exp_addr);
            chk($sformatf("v%0d be", idx), 32'(dmem_be_o), 32'(v.exp_be));
            chk($sformatf("v%0d we", idx), 32'(dmem_we_o), 32'(v.exp_dwe));
            if (v.exp_dwe) chk($sformatf("v%0d wdata", idx), dmem_wdata_o, v.exp_wdata);
            for (int k = 1; k <= v.dly; k++) begin
                cyc();
                dmem_gnt_i = 1'b0;
                if (k == v.dly) begin
                    dmem_rvalid_i = 1'b1;
                    dmem_rdata_i = v.rdata;
                end
                @(negedge clk_i);
                chk($sformatf("v%0d stall%0d", idx, k), 32'(stall_o), (k == v.dly) ? 32'd0 : 32'd1);
                chk($sformatf("v%0d bubble%0d", idx, k), 32'(rd_write_enable_o), 32'd0);
            end
        end
        cyc();
        dmem_rvalid_i = 1'b0;
        dmem_gnt_i = 1'b0;
        chk($sformatf("v%0d rd_we", idx), 32'(rd_write_enable_o), 32'(v.exp_we));
        chk($sformatf("v%0d mis", idx), 32'(misaligned_o), 32'(v.exp_mis));
        chk($sformatf("v%0d rf_addr", idx), 32'(rf_addr_o), 32'(idx + 1));
        chk($sformatf("v%0d pc", idx), pc_o, pc_e);
        chk($sformatf("v%0d op", idx), 32'(operation_o), 32'(v.op));
        chk($sformatf("v%0d bus_err", idx), 32'(bus_err_o), 32'd0);
        if (v.chk_rd) chk($sformatf("v%0d rd_data", idx), rd_data_o, v.exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_stall;
        //            rd wr f3     raddr   waddr        wdata         alu           rdata         dly req be       addr         wdata         rd            chk we mis
        vt[0]  = mk(0, 0, 3'b000, 10'h0,  32'h0,       32'h0,        32'h12345678, 32'h0,        1, 0, 4'b0000, 32'h0,       32'h0,        32'h12345678, 1, 1, 0);
        vt[1]  = mk(0, 0, 3'b000, 10'h0,  32'h0,       32'h0,        32'hCAFEF00D, 32'h0,        1, 0, 4'b0000, 32'h0,       32'h0,        32'hCAFEF00D, 1, 1, 0);
        vt[1].rwe = 1'b0; vt[1].exp_we = 1'b0;
        vt[2]  = mk(1, 0, 3'b010, 10'h010, 32'h0,      32'h0,        32'h0,        32'hDEADBEEF, 3, 1, 4'b1111, 32'h010,     32'h0,        32'hDEADBEEF, 1, 1, 0);
        vt[3]  = mk(1, 0, 3'b000, 10'h013, 32'h0,      32'h0,        32'h0,        32'h80FFFFFF, 1, 1, 4'b1000, 32'h010,     32'h0,        32'hFFFFFF80, 1, 1, 0);
        vt[4]  = mk(1, 0, 3'b100, 10'h013, 32'h0,      32'h0,        32'h0,        32'h80FFFFFF, 1, 1, 4'b1000, 32'h010,     32'h0,        32'h00000080, 1, 1, 0);
        vt[5]  = mk(1, 0, 3'b001, 10'h012, 32'h0,      32'h0,        32'h0,        32'h80011234, 2, 1, 4'b1100, 32'h010,     32'h0,        32'hFFFF8001, 1, 1, 0);
        vt[6]  = mk(1, 0, 3'b101, 10'h012, 32'h0,      32'h0,        32'h0,        32'h80011234, 1, 1, 4'b1100, 32'h010,     32'h0,        32'h00008001, 1, 1, 0);
        vt[7]  = mk(1, 0, 3'b001, 10'h010, 32'h0,      32'h0,        32'h0,        32'h80017234, 1, 1, 4'b0011, 32'h010,     32'h0,        32'h00007234, 1, 1, 0);
        vt[8]  = mk(1, 0, 3'b000, 10'h011, 32'h0,      32'h0,        32'h0,        32'h00007F00, 1, 1, 4'b0010, 32'h010,     32'h0,        32'h0000007F, 1, 1, 0);
        vt[9]  = mk(0, 1, 3'b001, 10'h0,  32'h102,     32'h0000ABCD, 32'h0,        32'h0,        2, 1, 4'b1100, 32'h100,     32'hABCDABCD, 32'h0,        0, 0, 0);
        vt[10] = mk(0, 1, 3'b000, 10'h0,  32'h203,     32'h11223344, 32'h0,        32'h0,        1, 1, 4'b1000, 32'h200,     32'h44444444, 32'h0,        0, 0, 0);
        vt[11] = mk(1, 1, 3'b010, 10'h3FC, 32'h300,    32'hA5A55A5A, 32'h0,        32'h0,        1, 1, 4'b1111, 32'h300,     32'hA5A55A5A, 32'h0,        0, 0, 0);
        vt[12] = mk(1, 0, 3'b010, 10'h006, 32'h0,      32'h0,        32'h0,        32'h0,        1, 0, 4'b0000, 32'h0,       32'h0,        32'h0,        0, 0, 1);
        vt[13] = mk(1, 0, 3'b001, 10'h011, 32'h0,      32'h0,        32'h0,        32'h0,        1, 0, 4'b0000, 32'h0,       32'h0,        32'h0,        0, 0, 1);
        vt[14] = mk(0, 1, 3'b010, 10'h0,  32'h102,     32'h0,        32'h0,        32'h0,        1, 0, 4'b0000, 32'h0,       32'h0,        32'h0,        0, 0, 1);
        vt[15] = mk(0, 1, 3'b001, 10'h0,  32'h203,     32'h0,        32'h0,        32'h0,        1, 0, 4'b0000, 32'h0,       32'h0,        32'h0,        0, 0, 1);

        // reset state
        set_idle();
        rstn_i = 1'b0;
        cyc();
        cyc();
        rstn_i = 1'b1;
        @(negedge clk_i);
        chk("rst rd_data", rd_data_o, 32'h0);
        chk("rst rd_we", 32'(rd_write_enable_o), 32'd0);
        chk("rst op", 32'(operation_o), 32'(ZERO));
        chk("rst req", 32'(dmem_req_o), 32'd0);
        chk("rst stall", 32'(stall_o), 32'd0);
        chk("rst mis", 32'(misaligned_o), 32'd0);
        chk("rst bus_err", 32'(bus_err_o), 32'd0);
        cyc();

        for (int i = 0; i < 16; i++) run_vec(vt[i], i);

        // grant delayed: request held stable in REQ, early rvalid ignored, bubble holds data
        set_idle();
        alu_data_i = 32'h55AA55AA; rd_write_enable_i = 1'b1; operation_i = ALU;
        cyc();
        chk("seqA alu", rd_data_o, 32'h55AA55AA);
        memory_read_enable_i = 1'b1; memory_read_addr_i = 10'h020;
        instruction_i = {17'd0, 3'b010, 12'h003}; operation_i = LOAD;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0BAD0BAD;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                dmem_gnt_i = 1'b1;
                dmem_rvalid_i = 1'b0;
            end
            @(negedge clk_i);
            chk($sformatf("seqA req%0d", k), 32'(dmem_req_o), 32'd1);
            chk($sformatf("seqA addr%0d", k), dmem_addr_o, 32'h020);
            chk($sformatf("seqA stall%0d", k), 32'(stall_o), 32'd1);
            cyc();
        end
        dmem_gnt_i = 1'b0;
        @(negedge clk_i);
        chk("seqA wait req", 32'(dmem_req_o), 32'd0);
        chk("seqA wait stall", 32'(stall_o), 32'd1);
        chk("seqA hold rd", rd_data_o, 32'h55AA55AA);
        chk("seqA hold we", 32'(rd_write_enable_o), 32'd0);
        cyc();
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h01020304;
        @(negedge clk_i);
        chk("seqA rvalid stall", 32'(stall_o), 32'd0);
        cyc();
        dmem_rvalid_i = 1'b0;
        chk("seqA rd", rd_data_o, 32'h01020304);
        chk("seqA we", 32'(rd_write_enable_o), 32'd1);

        // reset while in WAIT, then a late rvalid
        memory_read_addr_i = 10'h040; dmem_gnt_i = 1'b1; pc_i = 32'h2222;
        cyc();
        dmem_gnt_i = 1'b0;
        @(negedge clk_i);
        chk("seqB wait stall", 32'(stall_o), 32'd1);
        cyc();
        rstn_i = 1'b0;
        cyc();
        rstn_i = 1'b1;
        set_idle();
        chk("seqB rd", rd_data_o, 32'h0);
        chk("seqB pc", pc_o, 32'h0);
        chk("seqB op", 32'(operation_o), 32'(ZERO));
        chk("seqB rf", 32'(rf_addr_o), 32'd0);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFFFFFF;
        @(negedge clk_i);
        chk("seqB late stall", 32'(stall_o), 32'd0);
        chk("seqB late req", 32'(dmem_req_o), 32'd0);
        cyc();
        dmem_rvalid_i = 1'b0;
        chk("seqB late rd", rd_data_o, 32'h0);
        chk("seqB late we", 32'(rd_write_enable_o), 32'd0);

`ifdef MEM_ACCESS_TIMEOUT_EN
        // granted access that never completes
        memory_read_enable_i = 1'b1; memory_read_addr_i = 10'h080;
        instruction_i = {17'd0, 3'b010, 12'h003}; rd_write_enable_i = 1'b1; operation_i = LOAD;
        dmem_gnt_i = 1'b1;
        cyc();
        dmem_gnt_i = 1'b0;
        n_stall = 0;
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk_i);
            if (stall_o) n_stall++;
            cyc();
        end
        chk("seqC stall cycles", 32'(n_stall), 32'd31);
        @(negedge clk_i);
        chk("seqC stall drop", 32'(stall_o), 32'd0);
        cyc();
        set_idle();
        chk("seqC bus_err", 32'(bus_err_o), 32'd1);
        chk("seqC we", 32'(rd_write_enable_o), 32'd0);
        cyc();
        chk("seqC bus_err pulse", 32'(bus_err_o), 32'd0);
`else
        n_stall = 0;
        chk("seqC bus_err tied", 32'(bus_err_o) + 32'(n_stall), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
